// File: rtl/fft_ram_buffer.sv
// Complex sample store for an in-place radix-2 FFT. It loads input in bit-reversed order,
// serves the butterfly read and write ports while the FFT runs, then unloads in natural order.
module fft_ram_buffer #(
  parameter int N     = 8,
  parameter int L_max = 3,
  parameter int DW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  // time-domain input stream
  input  logic             din_valid,
  input  logic [DW-1:0]    din_re,
  input  logic [DW-1:0]    din_im,
  output logic             din_ready,
  output logic             initial_flag,
  // butterfly read port pair
  input  logic             rd_en,
  input  logic [L_max-1:0] rd_add1,
  input  logic [L_max-1:0] rd_add2,
  output logic             rd_valid,
  output logic [DW-1:0]    a_re,
  output logic [DW-1:0]    a_im,
  output logic [DW-1:0]    b_re,
  output logic [DW-1:0]    b_im,
  // butterfly write port pair
  input  logic             wr_en,
  input  logic [L_max-1:0] wr_add1,
  input  logic [L_max-1:0] wr_add2,
  input  logic [DW-1:0]    wa_re,
  input  logic [DW-1:0]    wa_im,
  input  logic [DW-1:0]    wb_re,
  input  logic [DW-1:0]    wb_im,
  // frequency-domain output stream
  input  logic             flag_fftfinish,
  output logic             dout_valid,
  output logic [DW-1:0]    dout_re,
  output logic [DW-1:0]    dout_im,
  output logic [L_max-1:0] dout_index,
  output logic             dout_last
);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_UNLOAD  = 2'd2
  } state_t;

  localparam logic [L_max-1:0] LAST_ADDR = L_max'(N - 1);

  state_t           state;
  logic [L_max-1:0] cnt;
  logic [L_max-1:0] ucnt;     // next unload address to issue
  logic             u_done;   // all N unload reads issued
  logic             u_valid;  // unload read stage holds a valid address
  logic [L_max-1:0] u_idx;

  logic [2*DW-1:0]  mem [N];

  logic load_fire;
  logic rd_fire;
  logic wr_fire;

  function automatic logic [L_max-1:0] bitrev(input logic [L_max-1:0] x);
    logic [L_max-1:0] r;
    for (int i = 0; i < L_max; i++) begin
      r[i] = x[L_max-1-i];
    end
    return r;
  endfunction

  // din_ready is only high in LOAD, so it doubles as the load-state qualifier.
  assign load_fire = (state == S_LOAD) && din_ready && din_valid;
  assign rd_fire   = (state == S_COMPUTE) && rd_en;
  assign wr_fire   = (state == S_COMPUTE) && wr_en;

  // NOTE: the sample store has no reset; a frame is always fully rewritten before it is read,
  // and leaving it unreset lets it map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[bitrev(cnt)] <= {din_re, din_im};
    end
    if (wr_fire) begin
      // B is written second so it overrides A when both target the same word.
      mem[wr_add1] <= {wa_re, wa_im};
      mem[wr_add2] <= {wb_re, wb_im};
    end
  end

  // NOTE: non-blocking reads of mem sample the value before this edge's writes,
  // which gives read-before-write on an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      a_re     <= '0;
      a_im     <= '0;
      b_re     <= '0;
      b_im     <= '0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) begin
        {a_re, a_im} <= mem[rd_add1];
        {b_re, b_im} <= mem[rd_add2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_LOAD;
      cnt          <= '0;
      din_ready    <= 1'b1;
      initial_flag <= 1'b0;
      ucnt         <= '0;
      u_done       <= 1'b0;
      u_valid      <= 1'b0;
      u_idx        <= '0;
    end else begin
      initial_flag <= 1'b0;
      case (state)
        S_LOAD: begin
          if (!din_ready) begin
            // one idle cycle after the final unloaded sample before accepting input
            din_ready <= 1'b1;
          end else if (load_fire) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_ADDR) begin
              state        <= S_COMPUTE;
              din_ready    <= 1'b0;
              initial_flag <= 1'b1;
            end
          end
        end

        S_COMPUTE: begin
          if (flag_fftfinish) begin
            state  <= S_UNLOAD;
            ucnt   <= '0;
            u_done <= 1'b0;
          end
        end

        S_UNLOAD: begin
          if (!u_done) begin
            u_valid <= 1'b1;
            u_idx   <= ucnt;
            ucnt    <= ucnt + 1'b1;
            if (ucnt == LAST_ADDR) begin
              u_done <= 1'b1;
            end
          end else begin
            u_valid <= 1'b0;
          end
          if (u_valid && (u_idx == LAST_ADDR)) begin
            state <= S_LOAD;
            cnt   <= '0;
          end
        end

        default: begin
          state     <= S_LOAD;
          cnt       <= '0;
          din_ready <= 1'b1;
          u_valid   <= 1'b0;
        end
      endcase
    end
  end

  // Second unload stage: registers the word addressed by the first stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_re    <= '0;
      dout_im    <= '0;
      dout_index <= '0;
      dout_last  <= 1'b0;
    end else begin
      dout_valid <= u_valid;
      dout_last  <= u_valid && (u_idx == LAST_ADDR);
      if (u_valid) begin
        {dout_re, dout_im} <= mem[u_idx];
        dout_index         <= u_idx;
      end
    end
  end

endmodule

// File: tb/tb_fft_ram_buffer.sv
// Directed bench for fft_ram_buffer: bit-reversed load, butterfly read/write, collisions,
// natural-order unload and reset mid-unload, checked against a queue-based scoreboard.
module tb_fft_ram_buffer;

  localparam int N  = 8;
  localparam int L  = 3;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din_valid = 1'b0;
  logic [DW-1:0] din_re = '0, din_im = '0;
  logic          din_ready, initial_flag;
  logic          rd_en = 1'b0;
  logic [L-1:0]  rd_add1 = '0, rd_add2 = '0;
  logic          rd_valid;
  logic [DW-1:0] a_re, a_im, b_re, b_im;
  logic          wr_en = 1'b0;
  logic [L-1:0]  wr_add1 = '0, wr_add2 = '0;
  logic [DW-1:0] wa_re = '0, wa_im = '0, wb_re = '0, wb_im = '0;
  logic          flag_fftfinish = 1'b0;
  logic          dout_valid;
  logic [DW-1:0] dout_re, dout_im;
  logic [L-1:0]  dout_index;
  logic          dout_last;

  always #10 clk = ~clk;

  fft_ram_buffer #(.N(N), .L_max(L), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din_re(din_re), .din_im(din_im),
    .din_ready(din_ready), .initial_flag(initial_flag),
    .rd_en(rd_en), .rd_add1(rd_add1), .rd_add2(rd_add2), .rd_valid(rd_valid),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .wr_en(wr_en), .wr_add1(wr_add1), .wr_add2(wr_add2),
    .wa_re(wa_re), .wa_im(wa_im), .wb_re(wb_re), .wb_im(wb_im),
    .flag_fftfinish(flag_fftfinish),
    .dout_valid(dout_valid), .dout_re(dout_re), .dout_im(dout_im),
    .dout_index(dout_index), .dout_last(dout_last)
  );

  typedef struct packed {
    logic [DW-1:0] a_re, a_im, b_re, b_im;
  } rd_exp_t;

  typedef struct packed {
    logic [L-1:0]  idx;
    logic [DW-1:0] re, im;
    logic          last;
  } out_exp_t;

  rd_exp_t       rd_q[$];
  out_exp_t      out_q[$];
  logic [DW-1:0] m_re [N];
  logic [DW-1:0] m_im [N];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [L-1:0] bitrev_m(input logic [L-1:0] x);
    logic [L-1:0] r;
    for (int i = 0; i < L; i++) r[i] = x[L-1-i];
    return r;
  endfunction

  function automatic rd_exp_t mk_rd(input logic [DW-1:0] ar, ai, br, bi);
    return '{a_re: ar, a_im: ai, b_re: br, b_im: bi};
  endfunction

  function automatic rd_exp_t model_rd(input logic [L-1:0] x1, x2);
    return mk_rd(m_re[x1], m_im[x1], m_re[x2], m_im[x2]);
  endfunction

  // Pops one expected read result whenever the DUT flags rd_valid.
  task automatic read_and_check(input string tag);
    rd_exp_t e;
    check({tag, "_rd_valid"}, rd_valid, 1'b1);
    if (rd_valid && rd_q.size() > 0) begin
      e = rd_q.pop_front();
      check({tag, "_a_re"}, a_re, e.a_re);
      check({tag, "_a_im"}, a_im, e.a_im);
      check({tag, "_b_re"}, b_re, e.b_re);
      check({tag, "_b_im"}, b_im, e.b_im);
    end
  endtask

  task automatic do_read(input string tag, input logic [L-1:0] x1, x2, input rd_exp_t e);
    rd_en = 1'b1; rd_add1 = x1; rd_add2 = x2;
    rd_q.push_back(e);
    tick();
    rd_en = 1'b0;
    read_and_check(tag);
  endtask

  // Streams N samples; noisy mode inserts gaps and drives rd/wr/flag, which LOAD must ignore.
  task automatic load_frame(input logic [DW-1:0] re0, im0, im_step, input bit noisy);
    for (int i = 0; i < N; i++) begin
      if (noisy) begin
        rd_en = 1'b1; wr_en = 1'b1; flag_fftfinish = 1'b1;
        wr_add1 = '0; wr_add2 = '0;
        wa_re = 16'hDEAD; wa_im = 16'hDEAD; wb_re = 16'hBEEF; wb_im = 16'hBEEF;
        if (i % 3 == 1) begin
          din_valid = 1'b0;
          tick();
          check("load_gap_rd_valid", rd_valid, 1'b0);
          check("load_gap_init_flag", initial_flag, 1'b0);
        end
      end
      din_valid = 1'b1;
      din_re = re0 + DW'(i);
      din_im = im0 + DW'(i) * im_step;
      tick();
      m_re[bitrev_m(L'(i))] = din_re;
      m_im[bitrev_m(L'(i))] = din_im;
      check("load_init_flag", initial_flag, (i == N - 1));
      check("load_din_ready", din_ready, (i != N - 1));
      if (noisy) check("load_rd_valid", rd_valid, 1'b0);
    end
    din_valid = 1'b0; rd_en = 1'b0; wr_en = 1'b0; flag_fftfinish = 1'b0;
    tick();
    check("init_flag_one_cycle", initial_flag, 1'b0);
    check("compute_din_ready", din_ready, 1'b0);
  endtask

  // Pulses flag_fftfinish and follows the unload; abort_after>0 asserts reset after that many outputs.
  task automatic run_unload(input int abort_after);
    out_exp_t e;
    int  first;
    int  nvalid;
    bit  aborted;
    bit  prev_last;
    bit  saw_rd_valid;
    first = -1; nvalid = 0; aborted = 1'b0; prev_last = 1'b0; saw_rd_valid = 1'b0;
    for (int k = 0; k < N; k++)
      out_q.push_back('{idx: L'(k), re: m_re[k], im: m_im[k], last: (k == N - 1)});
    flag_fftfinish = 1'b1;
    tick();
    flag_fftfinish = 1'b0;
    // UNLOAD must ignore both butterfly ports; the junk write targets the last bin.
    wr_en = 1'b1; wr_add1 = L'(N - 1); wr_add2 = L'(N - 1);
    wa_re = 16'h5A5A; wa_im = 16'h5A5A; wb_re = 16'hA5A5; wb_im = 16'hA5A5;
    rd_en = 1'b1;
    for (int c = 1; c <= N + 3 && !aborted; c++) begin
      tick();
      wr_en = 1'b0;
      if (rd_valid) saw_rd_valid = 1'b1;
      if (prev_last) begin
        check("ready_after_last", din_ready, 1'b1);
        check("valid_after_last", dout_valid, 1'b0);
      end
      prev_last = dout_valid && dout_last;
      if (dout_valid) begin
        if (first < 0) first = c;
        nvalid++;
        if (out_q.size() > 0) begin
          e = out_q.pop_front();
          check("dout_index", dout_index, e.idx);
          check("dout_re", dout_re, e.re);
          check("dout_im", dout_im, e.im);
          check("dout_last", dout_last, e.last);
          if (e.last) check("ready_during_last", din_ready, 1'b0);
        end else begin
          check("dout_extra", dout_valid, 1'b0);
        end
        if (abort_after > 0 && nvalid == abort_after) begin
          rst = 1'b1;
          aborted = 1'b1;
        end
      end
    end
    rd_en = 1'b0;
    check("unload_rd_valid_seen", saw_rd_valid, 1'b0);
    if (aborted) begin
      tick();
      check("abort_dout_valid", dout_valid, 1'b0);
      check("abort_din_ready", din_ready, 1'b1);
      check("abort_dout_last", dout_last, 1'b0);
      rst = 1'b0;
      out_q.delete();
    end else begin
      check("unload_first_offset", first, 2);
      check("unload_count", nvalid, N);
      check("unload_queue_empty", out_q.size(), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_din_ready", din_ready, 1'b1);
    check("rst_initial_flag", initial_flag, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_ab", {a_re, a_im, b_re, b_im}, 64'h0);
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_dout", {dout_re, dout_im, dout_index, dout_last}, 0);
    rst = 1'b0;
    tick();
    check("post_rst_din_ready", din_ready, 1'b1);

    // Frame 1: re=0..7, im=0 on consecutive cycles
    load_frame(16'd0, 16'd0, 16'd0, 1'b0);

    // din_valid in COMPUTE must be dropped
    din_valid = 1'b1; din_re = 16'h7777; din_im = 16'h7777;
    tick();
    tick();
    din_valid = 1'b0;
    check("compute_din_ready_hold", din_ready, 1'b0);
    check("compute_no_init_flag", initial_flag, 1'b0);

    // Bit-reversed placement, checked against literal values
    do_read("br01", 3'd0, 3'd1, mk_rd(16'd0, 16'd0, 16'd4, 16'd0));
    do_read("br23", 3'd2, 3'd3, mk_rd(16'd2, 16'd0, 16'd6, 16'd0));
    do_read("br45", 3'd4, 3'd5, mk_rd(16'd1, 16'd0, 16'd5, 16'd0));
    do_read("br67", 3'd6, 3'd7, mk_rd(16'd3, 16'd0, 16'd7, 16'd0));
    tick();
    check("idle_rd_valid", rd_valid, 1'b0);
    check("hold_a_re", a_re, 16'd3);
    check("hold_b_re", b_re, 16'd7);

    // Read latency
    do_read("lat15", 3'd1, 3'd5, mk_rd(16'd4, 16'd0, 16'd5, 16'd0));

    // Write then read on the next cycle
    wr_en = 1'b1; wr_add1 = 3'd2; wr_add2 = 3'd3;
    wa_re = 16'h1234; wa_im = 16'h00AA; wb_re = 16'h8000; wb_im = 16'h0055;
    tick();
    wr_en = 1'b0;
    m_re[2] = 16'h1234; m_im[2] = 16'h00AA; m_re[3] = 16'h8000; m_im[3] = 16'h0055;
    do_read("wr_rd23", 3'd2, 3'd3, mk_rd(16'h1234, 16'h00AA, 16'h8000, 16'h0055));

    // Read/write collision: read returns pre-write data
    rd_en = 1'b1; rd_add1 = 3'd6; rd_add2 = 3'd5;
    rd_q.push_back(model_rd(3'd6, 3'd5));
    wr_en = 1'b1; wr_add1 = 3'd6; wr_add2 = 3'd5;
    wa_re = 16'h0A0A; wa_im = 16'h0B0B; wb_re = 16'h0C0C; wb_im = 16'h0D0D;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    read_and_check("rbw_old");
    m_re[6] = 16'h0A0A; m_im[6] = 16'h0B0B; m_re[5] = 16'h0C0C; m_im[5] = 16'h0D0D;
    do_read("rbw_new", 3'd6, 3'd5, model_rd(3'd6, 3'd5));

    // Same-address A/B write: B wins
    wr_en = 1'b1; wr_add1 = 3'd0; wr_add2 = 3'd0;
    wa_re = 16'h1111; wa_im = 16'h1111; wb_re = 16'h2222; wb_im = 16'h2222;
    tick();
    wr_en = 1'b0;
    m_re[0] = 16'h2222; m_im[0] = 16'h2222;
    do_read("b_wins", 3'd0, 3'd0, mk_rd(16'h2222, 16'h2222, 16'h2222, 16'h2222));

    // Unload with a butterfly write committed on the flag cycle
    wr_en = 1'b1; wr_add1 = 3'd1; wr_add2 = 3'd4;
    wa_re = 16'h7FFF; wa_im = 16'h8001; wb_re = 16'hFFFF; wb_im = 16'h0001;
    m_re[1] = 16'h7FFF; m_im[1] = 16'h8001; m_re[4] = 16'hFFFF; m_im[4] = 16'h0001;
    run_unload(0);

    // Frame 2 with gaps and ignored rd/wr/flag traffic, then reset in the 4th unload cycle
    load_frame(16'h0100, 16'h0F00, 16'h0010, 1'b1);
    do_read("f2_07", 3'd0, 3'd7, model_rd(3'd0, 3'd7));
    do_read("f2_34", 3'd3, 3'd4, model_rd(3'd3, 3'd4));
    run_unload(4);

    // Frame 3 after the abort, crossing the signed boundary
    load_frame(16'h7FFC, 16'h8003, 16'hFFFF, 1'b0);
    do_read("f3_16", 3'd1, 3'd6, model_rd(3'd1, 3'd6));
    run_unload(0);

    check("rd_queue_empty", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
